// File: rtl/or1200_except_arb_if.sv
// Handshake bundle between trigger/flush/vector logic and the
// or1200 exception arbiter.
interface or1200_except_arb_if #(
    parameter int TRIG_W = 14,
    parameter int TYPE_W = 4
);
    logic [TRIG_W-1:0] except_trig_i;
    logic              sr_tee_i;
    logic              sr_iee_i;
    logic              freeze_i;
    logic              flush_ack_i;
    logic              vec_done_i;
    logic [TYPE_W-1:0] except_type_o;
    logic              except_start_o;
    logic              epcr_we_o;
    logic              esr_we_o;
    logic              flush_req_o;
    logic              dbg_trap_o;
    logic              busy_o;

    modport master (
        output except_trig_i, sr_tee_i, sr_iee_i,
        output freeze_i, flush_ack_i, vec_done_i,
        input  except_type_o, except_start_o,
        input  epcr_we_o, esr_we_o,
        input  flush_req_o, dbg_trap_o, busy_o
    );

    modport slave (
        input  except_trig_i, sr_tee_i, sr_iee_i,
        input  freeze_i, flush_ack_i, vec_done_i,
        output except_type_o, except_start_o,
        output epcr_we_o, esr_we_o,
        output flush_req_o, dbg_trap_o, busy_o
    );
endinterface

// File: rtl/or1200_except_arb.sv
// Exception arbiter: latches triggers, picks a fixed-priority
// winner and sequences flush, drain and vector fetch.
module or1200_except_arb #(
    parameter int TRIG_W    = 14,
    parameter int TYPE_W    = 4,
    parameter int FLUSH_CYC = 3
) (
    input logic clk,
    input logic rst,
    or1200_except_arb_if.slave bus
);
    localparam int IDX_W = $clog2(TRIG_W);
    localparam logic [TYPE_W-1:0] TRAP_TYPE = TYPE_W'(4'he);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, VEC} state_t;

    state_t              state, state_d;
    logic [TRIG_W-1:2]   pend, pend_d;
    logic [2:0]          cnt, cnt_d;
    logic [TYPE_W-1:0]   typ, typ_d;
    logic                start_q, start_d;
    logic                trap_q, trap_d;
    logic [TRIG_W-1:0]   cand;
    logic [IDX_W-1:0]    win;
    logic [TYPE_W-1:0]   win_type;
    logic                sel;

    assign cand = {pend | bus.except_trig_i[TRIG_W-1:2],
                   bus.except_trig_i[1] & bus.sr_iee_i,
                   bus.except_trig_i[0] & bus.sr_tee_i};

    always_comb begin
        win = '0;
        for (int i = 0; i < TRIG_W; i++)
            if (cand[i]) win = IDX_W'(i);
    end

    always_comb begin
        win_type = '0;
        case (win)
            4'd0:    win_type = 4'h5;
            4'd1:    win_type = 4'h8;
            4'd2:    win_type = 4'hd;
            4'd3:    win_type = 4'hb;
            4'd4:    win_type = 4'h3;
            4'd5:    win_type = 4'hc;
            4'd6:    win_type = 4'he;
            4'd7:    win_type = 4'h9;
            4'd8:    win_type = 4'h6;
            4'd9:    win_type = 4'h7;
            4'd10:   win_type = 4'h2;
            4'd11:   win_type = 4'h4;
            4'd12:   win_type = 4'h2;
            4'd13:   win_type = 4'ha;
            default: win_type = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        typ_d   = typ;
        start_d = 1'b0;
        trap_d  = 1'b0;
        sel     = 1'b0;
        case (state)
            IDLE: begin
                if (|cand && !bus.freeze_i) begin
                    state_d = REQ;
                    typ_d   = win_type;
                    start_d = 1'b1;
                    sel     = 1'b1;
                end
            end
            REQ: begin
                if (bus.flush_ack_i) begin
                    state_d = DRAIN;
                    cnt_d   = 3'(FLUSH_CYC - 1);
                end
            end
            DRAIN: begin
                if (cnt == 3'd0) begin
                    if (typ == TRAP_TYPE) begin
                        state_d = IDLE;
                        trap_d  = 1'b1;
                    end else begin
                        state_d = VEC;
                    end
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            VEC: begin
                if (bus.vec_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A winner taken straight from the trigger line is consumed; a
    // re-assertion while its pending bit is being cleared is kept.
    always_comb begin
        pend_d = pend;
        for (int i = 2; i < TRIG_W; i++) begin
            if (sel && win == IDX_W'(i))
                pend_d[i] = pend[i] & bus.except_trig_i[i];
            else
                pend_d[i] = pend[i] | bus.except_trig_i[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pend    <= '0;
            cnt     <= '0;
            typ     <= '0;
            start_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state   <= state_d;
            pend    <= pend_d;
            cnt     <= cnt_d;
            typ     <= typ_d;
            start_q <= start_d;
            trap_q  <= trap_d;
        end
    end

    assign bus.except_type_o  = (state == IDLE) ? '0 : typ;
    assign bus.except_start_o = start_q;
    assign bus.epcr_we_o      = start_q;
    assign bus.esr_we_o       = start_q;
    assign bus.flush_req_o    = (state == REQ);
    assign bus.dbg_trap_o     = trap_q;
    assign bus.busy_o         = (state != IDLE);
endmodule

// File: tb/tb_or1200_except_arb.sv
// Directed vector bench for the exception arbiter.
module tb_or1200_except_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;

    or1200_except_arb_if bus ();

    or1200_except_arb #(
        .TRIG_W(14), .TYPE_W(4), .FLUSH_CYC(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] trig;
        logic        tee, iee, frz, ack, done;
        logic [3:0]  ty;
        logic        st, fl, tr, bz;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic v(input logic [13:0] trig,
                     input logic tee, iee, frz, ack, done,
                     input logic [3:0] ty,
                     input logic st, fl, tr, bz);
        vec_t r;
        r.trig = trig; r.tee = tee; r.iee = iee;
        r.frz = frz; r.ack = ack; r.done = done;
        r.ty = ty; r.st = st; r.fl = fl; r.tr = tr; r.bz = bz;
        vt.push_back(r);
    endtask

    task automatic drive(input logic [13:0] trig,
                         input logic tee, iee, frz, ack, done);
        bus.except_trig_i = trig;
        bus.sr_tee_i      = tee;
        bus.sr_iee_i      = iee;
        bus.freeze_i      = frz;
        bus.flush_ack_i   = ack;
        bus.vec_done_i    = done;
    endtask

    task automatic chk(input string nm, input logic [3:0] ty,
                       input logic st, fl, tr, bz);
        logic [9:0] got, exp;
        got = {bus.except_type_o, bus.except_start_o, bus.epcr_we_o,
               bus.esr_we_o, bus.flush_req_o, bus.dbg_trap_o, bus.busy_o};
        exp = {ty, st, st, st, fl, tr, bz};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {type,start,epcr,esr,flush,trap,busy}=%b exp=%b",
                     nm, got, exp);
        end
    endtask

    task automatic step(input string nm, input logic [13:0] trig,
                        input logic tee, iee, frz, ack, done,
                        input logic [3:0] ty, input logic st, fl, tr, bz);
        @(negedge clk);
        drive(trig, tee, iee, frz, ack, done);
        @(posedge clk);
        #1;
        chk(nm, ty, st, fl, tr, bz);
    endtask

    initial begin
        // T1: TRAP, ack one cycle late, debug hand-off without VEC
        v(14'h0040, 0,0,0,0,0, 4'he, 1,1,0,1);
        v(14'h0000, 0,0,0,0,0, 4'he, 0,1,0,1);
        v(14'h0000, 0,0,0,1,0, 4'he, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'he, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'he, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h0, 0,0,1,0);
        v(14'h0000, 0,0,0,0,0, 4'h0, 0,0,0,0);
        // T2: ITLBMISS first, ILLEGAL from pend, TICK dropped
        v(14'h2201, 1,0,0,0,0, 4'ha, 1,1,0,1);
        v(14'h0000, 1,0,0,1,0, 4'ha, 0,0,0,1);
        v(14'h0000, 1,0,0,0,1, 4'ha, 0,0,0,1);
        v(14'h0000, 1,0,0,0,0, 4'ha, 0,0,0,1);
        v(14'h0000, 1,0,0,0,0, 4'ha, 0,0,0,1);
        v(14'h0000, 1,0,0,0,1, 4'h0, 0,0,0,0);
        v(14'h0000, 1,0,0,0,0, 4'h7, 1,1,0,1);
        v(14'h0000, 1,0,0,1,0, 4'h7, 0,0,0,1);
        v(14'h0000, 1,0,0,0,0, 4'h7, 0,0,0,1);
        v(14'h0000, 1,0,0,0,0, 4'h7, 0,0,0,1);
        v(14'h0000, 1,0,0,0,0, 4'h7, 0,0,0,1);
        v(14'h0000, 1,0,0,0,1, 4'h0, 0,0,0,0);
        v(14'h0000, 1,0,0,0,0, 4'h0, 0,0,0,0);
        // T3: INT gated by sr_iee_i
        v(14'h0002, 0,0,0,0,0, 4'h0, 0,0,0,0);
        v(14'h0002, 0,1,0,0,0, 4'h8, 1,1,0,1);
        v(14'h0000, 0,0,0,1,0, 4'h8, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h8, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h8, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h8, 0,0,0,1);
        v(14'h0000, 0,0,0,0,1, 4'h0, 0,0,0,0);
        // T4: SYSCALL held off by freeze_i
        v(14'h0020, 0,0,1,0,0, 4'h0, 0,0,0,0);
        for (int i = 0; i < 4; i++)
            v(14'h0000, 0,0,1,0,0, 4'h0, 0,0,0,0);
        v(14'h0000, 0,0,0,0,0, 4'hc, 1,1,0,1);
        v(14'h0000, 0,0,0,1,0, 4'hc, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'hc, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'hc, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'hc, 0,0,0,1);
        v(14'h0000, 0,0,0,0,1, 4'h0, 0,0,0,0);
        // T6: ALIGN re-asserted while its pend is cleared
        v(14'h0100, 0,0,1,0,0, 4'h0, 0,0,0,0);
        v(14'h0100, 0,0,0,0,0, 4'h6, 1,1,0,1);
        v(14'h0000, 0,0,0,1,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,1, 4'h0, 0,0,0,0);
        v(14'h0000, 0,0,0,0,0, 4'h6, 1,1,0,1);
        v(14'h0000, 0,0,0,1,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,0, 4'h6, 0,0,0,1);
        v(14'h0000, 0,0,0,0,1, 4'h0, 0,0,0,0);
        v(14'h0000, 0,0,0,0,0, 4'h0, 0,0,0,0);
        // stray ack/done while idle
        v(14'h0000, 0,0,0,1,1, 4'h0, 0,0,0,0);

        drive(14'h0, 0, 0, 0, 0, 0);
        #2;
        chk("reset", 4'h0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].trig, vt[i].tee, vt[i].iee,
                  vt[i].frz, vt[i].ack, vt[i].done);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vt[i].ty, vt[i].st,
                vt[i].fl, vt[i].tr, vt[i].bz);
        end

        // T5: reset during DRAIN with DPF pending
        step("t5_req", 14'h0810, 0,0,0,0,0, 4'h4, 1,1,0,1);
        step("t5_drain", 14'h0000, 0,0,0,1,0, 4'h4, 0,0,0,1);
        @(negedge clk);
        drive(14'h0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 chk("t5_rst", 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            step($sformatf("t5_post%0d", i), 14'h0, 0,0,0,0,0,
                 4'h0, 0,0,0,0);

        // reset during REQ drops flush_req_o without an ack
        step("rq_req", 14'h0008, 0,0,0,0,0, 4'hb, 1,1,0,1);
        @(negedge clk);
        drive(14'h0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 chk("rq_rst", 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step("rq_post", 14'h0, 0,0,0,1,0, 4'h0, 0,0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
